// File: rtl/dcache_store_port_pkg.sv
// Shared constants and state type for the store-port data cache.
package dcache_store_port_pkg;

  localparam int DC_ADDR_WIDTH = 32;
  localparam int DC_DATA_WIDTH = 32;
  localparam int DC_NLINES     = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WB   = 1'b1
  } dc_state_e;

endpackage

// File: rtl/dcache_store_port.sv
// Direct-mapped write-back cache of one-word lines fed by the store buffer;
// dirty victims leave through a valid/ready port, loads get a registered lookup.
module dcache_store_port
  import dcache_store_port_pkg::*;
#(
  parameter int ADDR_WIDTH = DC_ADDR_WIDTH,
  parameter int DATA_WIDTH = DC_DATA_WIDTH,
  parameter int NLINES     = DC_NLINES
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             sb_valid,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] sb_entry,
  output logic                             sb_ack,
  input  logic                             ld_valid,
  input  logic [ADDR_WIDTH-1:0]            ld_addr,
  output logic                             cache_hit,
  output logic [DATA_WIDTH-1:0]            ld_data,
  output logic                             mem_req,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic                             mem_ready
);

  localparam int IDXW = $clog2(NLINES);
  localparam int TAGW = ADDR_WIDTH - IDXW - 2;
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~{{(ADDR_WIDTH-2){1'b0}}, 2'b11};

  dc_state_e             state_q, state_d;
  logic [NLINES-1:0]     valid_q, valid_d;
  logic [NLINES-1:0]     dirty_q, dirty_d;
  logic [TAGW-1:0]       tag_q  [NLINES];
  logic [TAGW-1:0]       tag_d  [NLINES];
  logic [DATA_WIDTH-1:0] data_q [NLINES];
  logic [DATA_WIDTH-1:0] data_d [NLINES];
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  cache_hit_q, cache_hit_d;
  logic [DATA_WIDTH-1:0] ld_data_q, ld_data_d;

  logic [ADDR_WIDTH-1:0] st_waddr, ld_waddr;
  logic [DATA_WIDTH-1:0] st_data;
  logic [IDXW-1:0]       st_idx, ld_idx, pend_idx;
  logic [TAGW-1:0]       st_tag, ld_tag, pend_tag;
  logic                  accept;

  // Word addresses with the byte offset cleared keep all compares word-granular.
  assign st_waddr = sb_entry[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH] & WORD_MASK;
  assign st_data  = sb_entry[DATA_WIDTH-1:0];
  assign ld_waddr = ld_addr & WORD_MASK;
  assign st_idx   = st_waddr[IDXW+1:2];
  assign st_tag   = st_waddr[ADDR_WIDTH-1:IDXW+2];
  assign ld_idx   = ld_waddr[IDXW+1:2];
  assign ld_tag   = ld_waddr[ADDR_WIDTH-1:IDXW+2];
  assign pend_idx = pend_addr_q[IDXW+1:2];
  assign pend_tag = pend_addr_q[ADDR_WIDTH-1:IDXW+2];

  assign sb_ack = reset && (state_q == ST_IDLE);
  assign accept = sb_valid && sb_ack;

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cache_hit = cache_hit_q;
  assign ld_data   = ld_data_q;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    data_d      = data_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cache_hit_d = 1'b0;
    ld_data_d   = ld_data_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (valid_q[st_idx] && dirty_q[st_idx] && (tag_q[st_idx] != st_tag)) begin
            // Victim leaves the array now so it stops hitting during write-back.
            pend_addr_d     = st_waddr;
            pend_data_d     = st_data;
            mem_addr_d      = {tag_q[st_idx], st_idx, 2'b00};
            mem_wdata_d     = data_q[st_idx];
            mem_req_d       = 1'b1;
            valid_d[st_idx] = 1'b0;
            state_d         = ST_WB;
          end else begin
            tag_d[st_idx]   = st_tag;
            data_d[st_idx]  = st_data;
            valid_d[st_idx] = 1'b1;
            dirty_d[st_idx] = 1'b1;
          end
        end
      end
      ST_WB: begin
        if (mem_ready) begin
          tag_d[pend_idx]   = pend_tag;
          data_d[pend_idx]  = pend_data_q;
          valid_d[pend_idx] = 1'b1;
          dirty_d[pend_idx] = 1'b1;
          mem_req_d         = 1'b0;
          state_d           = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ld_valid) begin
      if (accept && (st_waddr == ld_waddr)) begin
        cache_hit_d = 1'b1;
        ld_data_d   = st_data;
      end else if ((state_q == ST_WB) && (pend_addr_q == ld_waddr)) begin
        cache_hit_d = 1'b1;
        ld_data_d   = pend_data_q;
      end else begin
        cache_hit_d = valid_q[ld_idx] && (tag_q[ld_idx] == ld_tag);
        ld_data_d   = data_q[ld_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cache_hit_q <= 1'b0;
      ld_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cache_hit_q <= cache_hit_d;
      ld_data_q   <= ld_data_d;
    end
  end

endmodule

// File: tb/tb_dcache_store_port.sv
// Directed self-checking bench for dcache_store_port with hand-computed expectations.
module tb_dcache_store_port;

  logic        clk;
  logic        reset;
  logic        sb_valid;
  logic [63:0] sb_entry;
  logic        sb_ack;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        cache_hit;
  logic [31:0] ld_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  dcache_store_port dut (
    .clk       (clk),
    .reset     (reset),
    .sb_valid  (sb_valid),
    .sb_entry  (sb_entry),
    .sb_ack    (sb_ack),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .cache_hit (cache_hit),
    .ld_data   (ld_data),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic sbv, input logic [63:0] entry,
                               input logic ldv, input logic [31:0] la,
                               input logic mr);
    sb_valid  = sbv;
    sb_entry  = entry;
    ld_valid  = ldv;
    ld_addr   = la;
    mem_ready = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkMemStable(input string name);
    checkOutput({name, "_req"},   mem_req,   1);
    checkOutput({name, "_addr"},  mem_addr,  32'hB8);
    checkOutput({name, "_wdata"}, mem_wdata, 32'h1234);
    checkOutput({name, "_ack"},   sb_ack,    0);
  endtask

  logic [31:0] burst_addr [4] = '{32'h40, 32'h44, 32'h1B8, 32'h4C};
  logic [31:0] burst_data [4] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};

  initial begin
    reset = 1'b0;
    applyStimulus(0, 64'h0, 0, 32'h0, 0);
    tick();
    tick();
    checkOutput("rst_ack",   sb_ack,    0);
    checkOutput("rst_req",   mem_req,   0);
    checkOutput("rst_addr",  mem_addr,  0);
    checkOutput("rst_wdata", mem_wdata, 0);
    checkOutput("rst_hit",   cache_hit, 0);
    checkOutput("rst_data",  ld_data,   0);
    reset = 1'b1;
    #1;
    checkOutput("ack_after_rst", sb_ack, 1);

    $display("[TB] clean allocate and load hit");
    applyStimulus(1, {32'hBB, 32'h1234}, 0, 32'h0, 0);
    checkOutput("ack_store1", sb_ack, 1);
    tick();
    applyStimulus(0, 64'h0, 1, 32'hB8, 0);
    tick();
    checkOutput("ld_b8_hit",  cache_hit, 1);
    checkOutput("ld_b8_data", ld_data,   32'h1234);
    applyStimulus(0, 64'h0, 0, 32'h0, 0);
    tick();
    checkOutput("idle_hit",  cache_hit, 0);
    checkOutput("idle_hold", ld_data,   32'h1234);

    $display("[TB] dirty miss write-back with stall");
    applyStimulus(1, {32'h1BB, 32'h5678}, 0, 32'h0, 0);
    tick();
    checkMemStable("wb0");
    applyStimulus(0, 64'h0, 1, 32'h1B8, 0);
    tick();
    checkMemStable("wb1");
    checkOutput("pend_hit",  cache_hit, 1);
    checkOutput("pend_data", ld_data,   32'h5678);
    applyStimulus(0, 64'h0, 1, 32'hB8, 0);
    tick();
    checkMemStable("wb2");
    checkOutput("victim_miss", cache_hit, 0);
    applyStimulus(0, 64'h0, 0, 32'h0, 0);
    tick();
    checkMemStable("wb3");
    applyStimulus(0, 64'h0, 0, 32'h0, 1);
    tick();
    checkOutput("wb_done_req", mem_req, 0);
    checkOutput("wb_done_ack", sb_ack,  1);
    applyStimulus(0, 64'h0, 1, 32'h1B8, 1);
    tick();
    checkOutput("stray_ready_req", mem_req,   0);
    checkOutput("ld_1b8_hit",      cache_hit, 1);
    checkOutput("ld_1b8_data",     ld_data,   32'h5678);
    applyStimulus(0, 64'h0, 1, 32'hB8, 0);
    tick();
    checkOutput("ld_b8_gone", cache_hit, 0);

    $display("[TB] same-edge store/load bypass");
    applyStimulus(1, {32'h40, 32'hABCD}, 1, 32'h40, 0);
    tick();
    checkOutput("byp_hit",  cache_hit, 1);
    checkOutput("byp_data", ld_data,   32'hABCD);
    checkOutput("byp_req",  mem_req,   0);

    $display("[TB] back-to-back stores to distinct lines");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, {burst_addr[i], burst_data[i]}, 0, 32'h0, 0);
      checkOutput($sformatf("burst_ack%0d", i), sb_ack, 1);
      tick();
      checkOutput($sformatf("burst_req%0d", i), mem_req, 0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 64'h0, 1, burst_addr[i], 0);
      tick();
      checkOutput($sformatf("burst_hit%0d", i),  cache_hit, 1);
      checkOutput($sformatf("burst_data%0d", i), ld_data,   burst_data[i]);
    end

    $display("[TB] reset during write-back");
    applyStimulus(1, {32'h80, 32'h7777}, 0, 32'h0, 0);
    tick();
    checkOutput("wb80_req",   mem_req,   1);
    checkOutput("wb80_addr",  mem_addr,  32'h40);
    checkOutput("wb80_wdata", mem_wdata, 32'hA1);
    applyStimulus(0, 64'h0, 0, 32'h0, 0);
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_ack", sb_ack, 0);
    tick();
    checkOutput("rst_mid_req", mem_req, 0);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_ack_back", sb_ack, 1);
    applyStimulus(0, 64'h0, 1, 32'hB8, 0);
    tick();
    checkOutput("post_rst_b8", cache_hit, 0);
    applyStimulus(0, 64'h0, 1, 32'h40, 0);
    tick();
    checkOutput("post_rst_40", cache_hit, 0);
    applyStimulus(0, 64'h0, 1, 32'h80, 0);
    tick();
    checkOutput("post_rst_80", cache_hit, 0);
    checkOutput("post_rst_req", mem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_store_port.md
# dcache_store_port

Receiving end of the store-buffer drain interface: accepts `{addr, data}` entries retired by the store buffer into a small direct-mapped, write-back data cache of one-word lines. Dirty victims are written back to main memory through a valid/ready port. The block also answers load lookups with a registered `cache_hit` and data, which the store buffer and load path consume. It sits between the store buffer and main memory in the Monocycle memory stage.

## Interface
- `ADDR_WIDTH`, 32, address width (from `header.vh`)
- `DATA_WIDTH`, 32, data width (from `header.vh`)
- `NLINES`, 4, cache lines; power of two, ≥2
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  synchronous reset, active-low: state is cleared at a rising edge where `reset==0`
- `sb_valid`  in  1  store buffer presents an entry (driven from `sending_data_to_cache`)
- `sb_entry`  in  ADDR_WIDTH+DATA_WIDTH  `{addr, data}`, addr in upper half
- `sb_ack`  out  1  ready; transfer at an edge with `sb_valid && sb_ack`
- `ld_valid`  in  1  load lookup request
- `ld_addr`  in  ADDR_WIDTH  load address
- `cache_hit`  out  1  registered lookup result
- `ld_data`  out  DATA_WIDTH  registered lookup data, valid when `cache_hit`
- `mem_req`  out  1  write-back request to memory
- `mem_addr`  out  ADDR_WIDTH  victim address
- `mem_wdata`  out  DATA_WIDTH  victim data
- `mem_ready`  in  1  memory accepts; transfer at an edge with `mem_req && mem_ready`

## Operation
- Address split: `idx = addr[IDXW+1:2]`, where `IDXW = log2(NLINES)`; `tag = addr[ADDR_WIDTH-1:IDXW+2]`; `addr[1:0]` is ignored. A reconstructed victim address has `[1:0] = 2'b00`.
- Per line: `valid`, `dirty`, `tag`, and `data`.
- FSM states:
  - **IDLE**: `sb_ack=1`. On a transfer:
    - Hit (valid and tag match), invalid line, or clean victim: write tag/data, set valid and dirty; stay in IDLE.
    - Valid, dirty, tag mismatch: latch the entry into `pend_*`, load `mem_addr`/`mem_wdata` with the victim, set `mem_req=1`, go to **WB**.
  - **WB**: `sb_ack=0`; `mem_req`, `mem_addr` and `mem_wdata` held stable. On `mem_ready`: write `pend_*` into the line (valid, dirty), drop `mem_req`, return to IDLE.
- Load lookup, every edge with `ld_valid`:
  - `cache_hit` = line valid and tag match; `ld_data` = line data.
  - Priority bypass: (1) a store accepted at this same edge with equal word address → hit with the new data; (2) in WB, `pend` address equal → hit with pend data.
  - The victim being written back no longer hits once WB is entered.
- With `ld_valid=0`: `cache_hit` ← 0; `ld_data` holds its value.
- Stores always hit-or-allocate. No read from memory is needed because lines are one word.

## Timing
- Reset values: FSM=IDLE, all valid/dirty=0, `mem_req=0`, `mem_addr=0`, `mem_wdata=0`, `cache_hit=0`, `ld_data=0`. `sb_ack=0` while `reset==0`.
- `sb_ack` is combinational from state and `reset` only, never from `sb_valid`.
- Hit or clean allocate: one entry per cycle, array updated at the accepting edge.
- Dirty miss: `mem_req` rises the cycle after acceptance. Minimum occupancy is 2 cycles (accept edge, then the `mem_ready` edge), plus any memory stall.
- Lookup latency: 1 cycle (registered).
- Reset asserted during WB: the write-back is abandoned, `mem_req` is 0 after the edge, and the pending entry is discarded. The store buffer is also reset, so no entry is lost architecturally.
- `sb_valid` during WB: ignored until the return to IDLE; the store buffer holds its entry.
- `mem_ready` while `mem_req=0`: ignored.

## Structure
- `header.vh` gains the `DC_NLINES` constant. `ADDR_WIDTH`, `DATA_WIDTH` and `SB_WIDTH` are reused. FSM state encodings are `localparam`s inside the module.
- There are no sub-modules. Tag, valid, dirty and data arrays are flat regs inside `dcache_store_port`.

## Test plan
- Reset, then store `{0x000000BB, 0x00001234}`: `sb_ack=1`, line 2 valid and dirty. A load of `0xB8` next cycle gives `cache_hit=1`, `ld_data=0x1234`.
- Store `0xBB/0x1234`, then `0x1BB/0x5678` (same index 2, dirty miss): `mem_req` rises with `mem_addr=0xB8`, `mem_wdata=0x1234`. Hold `mem_ready=0` for 3 cycles: `sb_ack=0` and outputs stable. On `mem_ready`, a load of `0x1B8` hits `0x5678`.
- Load `0x1B8` during that WB: hit via pend bypass with `0x5678`. Load `0xB8`: `cache_hit=0`.
- Store and load to `0x40` at the same edge: next cycle `cache_hit=1` with the stored data.
- Reset pulled low mid-WB: after the edge `mem_req=0`, all lines invalid, and a load of `0xB8` misses.
- Four stores to distinct indices back-to-back: four acks in four cycles and `mem_req` never asserted.
